// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller with 2-flop comparator sync
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     bit_idx, bit_idx_nxt;
    logic [WIDTH-1:0]  code, code_nxt;
    logic [WIDTH-1:0]  res_q, res_nxt;
    logic [WIDTH-1:0]  decided;
    logic              cmp_meta, cmp_s;

    // cmp_in is asynchronous to clk; only cmp_s may be used by the decision logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            code    <= '0;
            res_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            code    <= code_nxt;
            res_q   <= res_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        code_nxt    = code;
        res_nxt     = res_q;
        decided     = code;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SAMPLE;
                    cnt_nxt   = '0;
                    code_nxt  = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt == CW'(SAMPLE_CYCLES - 1)) begin
                    state_nxt   = S_SETTLE;
                    cnt_nxt     = '0;
                    bit_idx_nxt = IW'(WIDTH - 1);
                    code_nxt    = {1'b1, {(WIDTH-1){1'b0}}};
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_nxt = S_DECIDE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DECIDE: begin
                // comparator low means Vin < trial: drop the bit under test
                if (!cmp_s) begin
                    decided[bit_idx] = 1'b0;
                end
                if (bit_idx != '0) begin
                    decided[bit_idx - IW'(1)] = 1'b1;
                    bit_idx_nxt = bit_idx - IW'(1);
                    state_nxt   = S_SETTLE;
                end else begin
                    state_nxt = S_DONE;
                    res_nxt   = decided;
                end
                code_nxt = decided;
            end
            S_DONE: begin
                if (cont || start) begin
                    state_nxt = S_SAMPLE;
                    cnt_nxt   = '0;
                    code_nxt  = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sample_en = (state == S_SAMPLE);
    assign busy      = (state == S_SAMPLE) || (state == S_SETTLE) || (state == S_DECIDE);
    assign done      = (state == S_DONE);
    assign dac_code  = code;
    assign result    = res_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - scoreboard bench for sar_adc_ctrl (8-bit default and 10-bit/settle-3 instances)
module tb_sar_adc_ctrl;

    typedef struct {
        int res;
        int lat;
        int gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, cont0 = 1'b0, cmp0;
    logic       start1 = 1'b0, cont1 = 1'b0, cmp1;
    logic       sample0, busy0, done0, sample1, busy1, done1;
    logic [7:0] dac0, res0;
    logic [9:0] dac1, res1, prev_dac1;
    bit         glitch_en = 1'b0;

    int vin[2];
    int mode[2];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt[2];
    int last_done[2];
    int last_dac[2];
    int last_res[2];

    exp_t sb[2][$];
    int   tq[2][$];

    logic [11:0] dac_v[2], res_v[2];
    logic        busy_v[2], done_v[2], samp_v[2];

    assign dac_v[0] = 12'(dac0);
    assign dac_v[1] = 12'(dac1);
    assign res_v[0] = 12'(res0);
    assign res_v[1] = 12'(res1);
    assign busy_v[0] = busy0;
    assign busy_v[1] = busy1;
    assign done_v[0] = done0;
    assign done_v[1] = done1;
    assign samp_v[0] = sample0;
    assign samp_v[1] = sample1;

    always #5 clk = ~clk;

    sar_adc_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont0), .cmp_in(cmp0),
        .sample_en(sample0), .dac_code(dac0), .busy(busy0), .done(done0), .result(res0)
    );

    sar_adc_ctrl #(.WIDTH(10), .SAMPLE_CYCLES(8), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cont(cont1), .cmp_in(cmp1),
        .sample_en(sample1), .dac_code(dac1), .busy(busy1), .done(done1), .result(res1)
    );

    // ideal comparator; dut1 optionally sees a wrong value for one clock after each DAC step
    always @(posedge clk) prev_dac1 <= dac1;

    always_comb begin
        cmp0 = (mode[0] == 1) ? 1'b1 : (mode[0] == 2) ? 1'b0 : (vin[0] >= int'(dac0));
        cmp1 = (mode[1] == 1) ? 1'b1 : (mode[1] == 2) ? 1'b0 : (vin[1] >= int'(dac1));
        if (glitch_en && (dac1 != prev_dac1)) cmp1 = ~cmp1;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // reference: binary search over the code space, one bit per step
    task automatic push_exp(int d, int v, int m, int gap);
        int   w;
        int   code;
        int   trial;
        bit   c;
        exp_t e;
        w    = (d == 0) ? 8 : 10;
        code = 0;
        for (int i = w - 1; i >= 0; i--) begin
            trial = code + (1 << i);
            tq[d].push_back(trial);
            c = (m == 1) ? 1'b1 : (m == 2) ? 1'b0 : (v >= trial);
            if (c) code = trial;
        end
        e.res = code;
        e.lat = 48;
        e.gap = gap;
        sb[d].push_back(e);
    endtask

    task automatic pulse_start(bit s0, bit s1);
        @(posedge clk);
        #1;
        start0 = s0;
        start1 = s1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_empty(int d, int budget);
        int n;
        n = 0;
        while ((sb[d].size() != 0 || busy_v[d] || done_v[d]) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("wait_done_in_budget_dut%0d", d), int'(n < budget), 1);
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_sample0"}, int'(sample0), 0);
        chk({tag, "_dac0"}, int'(dac0), 0);
        chk({tag, "_busy0"}, int'(busy0), 0);
        chk({tag, "_done0"}, int'(done0), 0);
        chk({tag, "_result0"}, int'(res0), 0);
        chk({tag, "_result1"}, int'(res1), 0);
        chk({tag, "_busy1"}, int'(busy1), 0);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            sb[d].delete();
            tq[d].delete();
            busy_cnt[d] = 0;
            last_dac[d] = 0;
            last_res[d] = 0;
        end
    endtask

    // monitor: every DUT observation is checked against the queues filled by stimulus
    initial begin
        exp_t e;
        int   t;
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0; last_done[d] = 0; last_dac[d] = 0; last_res[d] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                for (int d = 0; d < 2; d++) begin
                    if (busy_v[d]) busy_cnt[d]++;
                    if (samp_v[d]) begin
                        last_dac[d] = 0;
                        chk($sformatf("sample_dac_zero_dut%0d", d), int'(dac_v[d]), 0);
                    end else if (busy_v[d] && int'(dac_v[d]) != last_dac[d]) begin
                        last_dac[d] = int'(dac_v[d]);
                        if (tq[d].size() == 0) begin
                            chk($sformatf("unexpected_trial_dut%0d", d), int'(dac_v[d]), -1);
                        end else begin
                            t = tq[d].pop_front();
                            chk($sformatf("trial_code_dut%0d", d), int'(dac_v[d]), t);
                        end
                    end
                    if (done_v[d]) begin
                        if (sb[d].size() == 0) begin
                            chk($sformatf("unexpected_done_dut%0d", d), 1, 0);
                        end else begin
                            e = sb[d].pop_front();
                            chk($sformatf("result_dut%0d", d), int'(res_v[d]), e.res);
                            chk($sformatf("busy_latency_dut%0d", d), busy_cnt[d], e.lat);
                            if (e.gap != 0)
                                chk($sformatf("done_gap_dut%0d", d), cyc - last_done[d], e.gap);
                        end
                        last_done[d] = cyc;
                        last_res[d]  = int'(res_v[d]);
                        busy_cnt[d]  = 0;
                    end else if (int'(res_v[d]) != last_res[d]) begin
                        chk($sformatf("result_held_dut%0d", d), int'(res_v[d]), last_res[d]);
                        last_res[d] = int'(res_v[d]);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int v0, v1, m0, m1;
        vin[0] = 0; vin[1] = 0; mode[0] = 0; mode[1] = 0;
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // ideal comparator, the worked 0xA5 example
        vin[0] = 'hA5; mode[0] = 0;
        push_exp(0, 'hA5, 0, 0);
        pulse_start(1'b1, 1'b0);
        wait_empty(0, 200);

        // tied comparator boundaries, ending on all-ones so reset has something to clear
        mode[0] = 2;
        push_exp(0, 0, 2, 0);
        pulse_start(1'b1, 1'b0);
        wait_empty(0, 200);
        mode[0] = 1;
        push_exp(0, 0, 1, 0);
        pulse_start(1'b1, 1'b0);
        wait_empty(0, 200);

        // start re-pulsed around clocks 10 and 30 is ignored
        mode[0] = 0; vin[0] = 'h5A;
        push_exp(0, 'h5A, 0, 0);
        pulse_start(1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (19) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_empty(0, 200);

        // reset mid-conversion clears everything asynchronously
        mode[0] = 1;
        push_exp(0, 0, 1, 0);
        pulse_start(1'b1, 1'b0);
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        clear_model();
        @(posedge clk);
        #2 rst = 1'b0;
        mode[0] = 0; vin[0] = 'h3C;
        push_exp(0, 'h3C, 0, 0);
        pulse_start(1'b1, 1'b0);
        wait_empty(0, 200);

        // continuous mode: two back-to-back conversions, then stop
        cont0 = 1'b1; vin[0] = 'h12;
        push_exp(0, 'h12, 0, 0);
        push_exp(0, 'hEE, 0, 49);
        pulse_start(1'b1, 1'b0);
        n = 0;
        while (!done0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cont_first_done_seen", int'(n < 100), 1);
        vin[0] = 'hEE;
        @(posedge clk);
        #1 cont0 = 1'b0;
        wait_empty(0, 200);
        repeat (60) @(posedge clk);
        #1;
        chk("cont_stopped_idle", int'(busy0), 0);

        // 10-bit instance with comparator glitches at each DAC step
        glitch_en = 1'b1;
        vin[1] = 'h2AB; mode[1] = 0;
        push_exp(1, 'h2AB, 0, 0);
        pulse_start(1'b0, 1'b1);
        wait_empty(1, 200);

        // randomized conversions on both instances in parallel
        for (int k = 0; k < 8; k++) begin
            v0 = $urandom_range(0, 255);
            v1 = $urandom_range(0, 1023);
            m0 = ($urandom_range(0, 3) == 3) ? $urandom_range(1, 2) : 0;
            m1 = ($urandom_range(0, 3) == 3) ? $urandom_range(1, 2) : 0;
            vin[0] = v0; mode[0] = m0;
            vin[1] = v1; mode[1] = m1;
            push_exp(0, v0, m0, 0);
            push_exp(1, v1, m1, 0);
            pulse_start(1'b1, 1'b1);
            wait_empty(0, 200);
            wait_empty(1, 200);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty_dut0", sb[0].size(), 0);
        chk("scoreboard_empty_dut1", sb[1].size(), 0);
        chk("trials_consumed_dut0", tq[0].size(), 0);
        chk("trials_consumed_dut1", tq[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
